// File: rtl/trace_pkg.sv
// -----------------------------------------------------------------------------
// trace_pkg
// Shared types for the writeback trace buffer.
//   trace_kind_t  : event kind stored with each entry (2 bits, 2/3 reserved)
//   trace_entry_t : one FIFO entry {kind, addr, data[, cycle]}
// Configuration macro: TRACE_CYCLE_STAMP_EN. When it is defined, the entry
// carries a cycle field. The field is TRACE_CYC_MAX bits wide so that any
// CYC_WIDTH up to that width fits. Unused upper bits are stored as constant
// zero.
// -----------------------------------------------------------------------------
package trace_pkg;

  typedef enum logic [1:0] {
    TRACE_GPR  = 2'd0,
    TRACE_HILO = 2'd1
  } trace_kind_t;

  localparam int TRACE_CYC_MAX = 64;

  typedef struct packed {
    trace_kind_t              kind;
    logic [4:0]               addr;
    logic [63:0]              data;
`ifdef TRACE_CYCLE_STAMP_EN
    logic [TRACE_CYC_MAX-1:0] cycle;
`endif
  } trace_entry_t;

  // Number of events presented to the FIFO in one cycle (0..2).
  function automatic logic [1:0] event_count(input logic a, input logic b);
    return {1'b0, a} + {1'b0, b};
  endfunction

endpackage

// File: rtl/wb_trace_fifo.sv
// -----------------------------------------------------------------------------
// wb_trace_fifo
// Circular buffer with 2 write ports and 1 read port.
// The pointers are $clog2(DEPTH)+1 bits wide. The extra bit tells a full
// buffer apart from an empty one.
//
// Handshake: the read side follows strict valid/ready semantics. rd_valid
// depends only on registered pointers. An entry leaves when rd_valid and
// rd_ready are both high on a rising edge. rd_data stays stable while
// rd_valid is high and rd_ready is low. On the write side, wr_en1 is
// honoured only together with wr_en0. The caller must never write more
// entries than free_slots reports.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   clear                 synchronous flush; a read or write in this cycle is dropped
//   wr_en0/wr_data0       first write (lands at the tail)
//   wr_en1/wr_data1       second write (lands behind the first)
//   rd_ready              consumer accepts the head entry
//   rd_valid/rd_data      head entry
//   level                 occupancy
//   free_slots            DEPTH - level + (this cycle's pop)
// -----------------------------------------------------------------------------
module wb_trace_fifo #(
  parameter  int DEPTH = 16,
  parameter  int W     = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int PW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          wr_en0,
  input  logic [W-1:0]  wr_data0,
  input  logic          wr_en1,
  input  logic [W-1:0]  wr_data1,
  input  logic          rd_ready,
  output logic          rd_valid,
  output logic [W-1:0]  rd_data,
  output logic [PW-1:0] level,
  output logic [PW-1:0] free_slots
);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr_nxt1;
  logic [PW-1:0] wr_cnt;
  logic          pop;
  logic          wr_both;

  assign level       = wr_ptr - rd_ptr;
  assign rd_valid    = (level != '0);
  assign pop         = rd_valid & rd_ready;
  // A pop on the same edge makes room for a push on that edge.
  assign free_slots  = PW'(DEPTH) - level + PW'(pop);
  assign wr_both     = wr_en0 & wr_en1;
  assign wr_cnt      = PW'(wr_en0) + PW'(wr_both);
  assign wr_ptr_nxt1 = wr_ptr + PW'(1);
  assign rd_data     = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      wr_ptr <= wr_ptr + wr_cnt;
      rd_ptr <= rd_ptr + PW'(pop);
    end
  end

  // Storage has no reset. Stale contents are never visible because the
  // pointers define what is valid and the top zeroes the outputs when empty.
  always_ff @(posedge clk) begin
    if (!clear) begin
      if (wr_en0) mem[wr_ptr[AW-1:0]] <= wr_data0;
      if (wr_both) mem[wr_ptr_nxt1[AW-1:0]] <= wr_data1;
    end
  end

endmodule

// File: rtl/wb_trace_buffer.sv
// -----------------------------------------------------------------------------
// wb_trace_buffer
// Writeback trace capture for cpu_core. Each cycle the block samples the
// writeback GPR write and the HI/LO write. It stamps each event with a cycle
// number and queues it in wb_trace_fifo. A valid/ready port drains the
// queue. When both events occur in one cycle, both are captured: HILO first,
// then GPR. Events that find no room are counted as drops; they are not
// lost silently.
//
// Configuration macro: TRACE_CYCLE_STAMP_EN
//   defined   : a cycle counter runs and each entry carries its stamp
//   undefined : no counter, no stamp storage, trace_cycle tied to 0
//
// Handshake: trace_valid/trace_ready follow strict valid/ready semantics.
// The head entry is accepted on a rising edge when both are high. The
// payload holds while trace_valid is high and trace_ready is low.
// trace_ready may depend combinationally on trace_valid.
//
// Ports:
//   clk_50M, reset_btn        clock, asynchronous active-high reset
//   capture_en                capture enable (the counter runs regardless)
//   clear                     synchronous flush of FIFO, counter, overflow, drops
//   wb_reg_waddr/wb_reg_wdata writeback GPR write
//   hilo_write_en/hilo_wval   HI/LO write, {hi, lo}
//   trace_valid/trace_ready   drain handshake
//   trace_kind/addr/data/cycle head entry payload, zero while trace_valid is low
//   overflow                  sticky drop flag
//   drop_count                saturating count of dropped events
//   level                     FIFO occupancy
// -----------------------------------------------------------------------------
module wb_trace_buffer
  import trace_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int CYC_WIDTH   = 32,
  parameter int FILTER_ZERO = 1,
  parameter int DROP_WIDTH  = 16
) (
  input  logic                    clk_50M,
  input  logic                    reset_btn,
  input  logic                    capture_en,
  input  logic                    clear,
  input  logic [4:0]              wb_reg_waddr,
  input  logic [31:0]             wb_reg_wdata,
  input  logic                    hilo_write_en,
  input  logic [63:0]             hilo_wval,
  output logic                    trace_valid,
  input  logic                    trace_ready,
  output logic [1:0]              trace_kind,
  output logic [4:0]              trace_addr,
  output logic [63:0]             trace_data,
  output logic [CYC_WIDTH-1:0]    trace_cycle,
  output logic                    overflow,
  output logic [DROP_WIDTH-1:0]   drop_count,
  output logic [$clog2(DEPTH):0]  level
);

  localparam int PW = $clog2(DEPTH) + 1;
  localparam int EW = $bits(trace_entry_t);

  trace_entry_t hilo_entry;
  trace_entry_t gpr_entry;
  trace_entry_t wr_entry0;
  trace_entry_t head;
  logic [EW-1:0] rd_data;
  logic [PW-1:0] free_slots;
  logic          capture;
  logic          hilo_ev;
  logic          gpr_ev;
  logic          hilo_acc;
  logic          gpr_acc;
  logic          wr_en0;
  logic          wr_en1;
  logic [1:0]    n_drop;
  logic [DROP_WIDTH:0] drop_sum;

  // ---------------------------------------------------------------------------
  // Cycle counter
  // ---------------------------------------------------------------------------
`ifdef TRACE_CYCLE_STAMP_EN
  logic [CYC_WIDTH-1:0] cyc_cnt;

  always_ff @(posedge clk_50M or posedge reset_btn) begin
    if (reset_btn) begin
      cyc_cnt <= '0;
    end else if (clear) begin
      cyc_cnt <= '0;
    end else begin
      cyc_cnt <= cyc_cnt + CYC_WIDTH'(1);
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Event qualification. Clear takes priority: events sampled while clear is
  // high are neither stored nor counted as drops.
  // ---------------------------------------------------------------------------
  assign capture = capture_en & ~clear;
  assign hilo_ev = capture & hilo_write_en;
  assign gpr_ev  = capture & (wb_reg_waddr != 5'd0) &
                   ((FILTER_ZERO == 0) || (wb_reg_wdata != 32'd0));

  // HILO has first claim on a free slot. GPR gets the slot after it.
  assign hilo_acc = hilo_ev & (free_slots != '0);
  assign gpr_acc  = gpr_ev & (hilo_ev ? (free_slots >= PW'(2)) : (free_slots != '0));
  assign n_drop   = event_count(hilo_ev & ~hilo_acc, gpr_ev & ~gpr_acc);

  always_comb begin
    hilo_entry      = '0;
    hilo_entry.kind = TRACE_HILO;
    hilo_entry.addr = 5'd0;
    hilo_entry.data = hilo_wval;
    gpr_entry       = '0;
    gpr_entry.kind  = TRACE_GPR;
    gpr_entry.addr  = wb_reg_waddr;
    gpr_entry.data  = {32'd0, wb_reg_wdata};
`ifdef TRACE_CYCLE_STAMP_EN
    hilo_entry.cycle = TRACE_CYC_MAX'(cyc_cnt);
    gpr_entry.cycle  = TRACE_CYC_MAX'(cyc_cnt);
`endif
  end

  // Pack the accepted events into the FIFO write ports in order.
  assign wr_en0    = hilo_acc | gpr_acc;
  assign wr_en1    = hilo_acc & gpr_acc;
  assign wr_entry0 = hilo_acc ? hilo_entry : gpr_entry;

  wb_trace_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk        (clk_50M),
    .rst        (reset_btn),
    .clear      (clear),
    .wr_en0     (wr_en0),
    .wr_data0   (wr_entry0),
    .wr_en1     (wr_en1),
    .wr_data1   (gpr_entry),
    .rd_ready   (trace_ready),
    .rd_valid   (trace_valid),
    .rd_data    (rd_data),
    .level      (level),
    .free_slots (free_slots)
  );

  // ---------------------------------------------------------------------------
  // Drop accounting
  // ---------------------------------------------------------------------------
  assign drop_sum = {1'b0, drop_count} + (DROP_WIDTH+1)'(n_drop);

  always_ff @(posedge clk_50M or posedge reset_btn) begin
    if (reset_btn) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (clear) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (n_drop != 2'd0) begin
      overflow   <= 1'b1;
      // A carry out of the adder means the count has hit all-ones.
      drop_count <= drop_sum[DROP_WIDTH] ? '1 : drop_sum[DROP_WIDTH-1:0];
    end
  end

  // ---------------------------------------------------------------------------
  // Output payload, zeroed while the FIFO is empty
  // ---------------------------------------------------------------------------
  assign head       = trace_entry_t'(rd_data);
  assign trace_kind = trace_valid ? 2'(head.kind) : 2'd0;
  assign trace_addr = trace_valid ? head.addr : 5'd0;
  assign trace_data = trace_valid ? head.data : 64'd0;

`ifdef TRACE_CYCLE_STAMP_EN
  logic unused_cycle_hi;
  assign unused_cycle_hi = ^head.cycle;
  assign trace_cycle     = trace_valid ? head.cycle[CYC_WIDTH-1:0] : '0;
`else
  assign trace_cycle = '0;
`endif

endmodule

// File: tb/tb_wb_trace_buffer.sv
// -----------------------------------------------------------------------------
// tb_wb_trace_buffer
// Bench for wb_trace_buffer (DEPTH 4, FILTER_ZERO 1). The scenario tasks
// drive inputs 1 time unit after each rising edge. A negedge monitor keeps a
// reference queue exp_q and checks the DUT against it every cycle: level,
// valid, overflow, drop count and the head payload. It then applies that
// cycle's pop and pushes. The scenario tasks also make targeted inline
// checks.
// -----------------------------------------------------------------------------
module tb_wb_trace_buffer;

  localparam int DEPTH      = 4;
  localparam int CYC_WIDTH  = 32;
  localparam int DROP_WIDTH = 16;
  localparam int LW         = $clog2(DEPTH) + 1;
  localparam int EW         = 2 + 5 + 64 + CYC_WIDTH;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk_50M = 1'b0;
  logic reset_btn = 1'b1;
  always #10 clk_50M = ~clk_50M;

  logic                  capture_en = 1'b0;
  logic                  clear = 1'b0;
  logic [4:0]            wb_reg_waddr = '0;
  logic [31:0]           wb_reg_wdata = '0;
  logic                  hilo_write_en = 1'b0;
  logic [63:0]           hilo_wval = '0;
  logic                  trace_valid;
  logic                  trace_ready = 1'b0;
  logic [1:0]            trace_kind;
  logic [4:0]            trace_addr;
  logic [63:0]           trace_data;
  logic [CYC_WIDTH-1:0]  trace_cycle;
  logic                  overflow;
  logic [DROP_WIDTH-1:0] drop_count;
  logic [LW-1:0]         level;

  wb_trace_buffer #(
    .DEPTH       (DEPTH),
    .CYC_WIDTH   (CYC_WIDTH),
    .FILTER_ZERO (1),
    .DROP_WIDTH  (DROP_WIDTH)
  ) dut (
    .clk_50M       (clk_50M),
    .reset_btn     (reset_btn),
    .capture_en    (capture_en),
    .clear         (clear),
    .wb_reg_waddr  (wb_reg_waddr),
    .wb_reg_wdata  (wb_reg_wdata),
    .hilo_write_en (hilo_write_en),
    .hilo_wval     (hilo_wval),
    .trace_valid   (trace_valid),
    .trace_ready   (trace_ready),
    .trace_kind    (trace_kind),
    .trace_addr    (trace_addr),
    .trace_data    (trace_data),
    .trace_cycle   (trace_cycle),
    .overflow      (overflow),
    .drop_count    (drop_count),
    .level         (level)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  // ---------------------------------------------------------------------------
  // Reference model state
  // ---------------------------------------------------------------------------
  logic [EW-1:0]         exp_q[$];
  logic [DROP_WIDTH-1:0] m_drops = '0;
  logic                  m_ovf = 1'b0;
  logic [CYC_WIDTH-1:0]  tb_cyc = '0;

  // Expected value of the DUT's free-running counter.
  always @(posedge clk_50M or posedge reset_btn) begin
    if (reset_btn)  tb_cyc <= '0;
    else if (clear) tb_cyc <= '0;
    else            tb_cyc <= tb_cyc + 1;
  end

  function automatic logic [CYC_WIDTH-1:0] stamp(input logic [CYC_WIDTH-1:0] c);
`ifdef TRACE_CYCLE_STAMP_EN
    return c;
`else
    return '0;
`endif
  endfunction

  function automatic logic [EW-1:0] mk(input logic [1:0] k, input logic [4:0] a,
                                       input logic [63:0] d, input logic [CYC_WIDTH-1:0] c);
    return {k, a, d, stamp(c)};
  endfunction

  task automatic model_drop();
    m_ovf = 1'b1;
    if (m_drops != '1) m_drops = m_drops + 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  // Scoreboard monitor (negedge, away from the active edge)
  // ---------------------------------------------------------------------------
  always @(negedge clk_50M) begin
    logic [EW-1:0] got;
    logic [EW-1:0] exp_head;
    int free;
    logic pop, hev, gev;
    if (reset_btn) begin
      exp_q.delete();
      m_drops = '0;
      m_ovf   = 1'b0;
    end else begin
      got      = {trace_kind, trace_addr, trace_data, trace_cycle};
      exp_head = (exp_q.size() != 0) ? exp_q[0] : '0;
      n_checks++;
      if (level !== LW'(exp_q.size()))
        $display("FAIL sb_level: got %0d expected %0d", level, exp_q.size());
      else n_pass++;
      n_checks++;
      if (trace_valid !== (exp_q.size() != 0))
        $display("FAIL sb_valid: got %0b expected %0b", trace_valid, exp_q.size() != 0);
      else n_pass++;
      n_checks++;
      if (got !== exp_head)
        $display("FAIL sb_head: got %0h expected %0h", got, exp_head);
      else n_pass++;
      n_checks++;
      if ({overflow, drop_count} !== {m_ovf, m_drops})
        $display("FAIL sb_drops: got ovf=%0b cnt=%0d expected ovf=%0b cnt=%0d",
                 overflow, drop_count, m_ovf, m_drops);
      else n_pass++;

      if (clear) begin
        exp_q.delete();
        m_drops = '0;
        m_ovf   = 1'b0;
      end else begin
        pop  = (exp_q.size() != 0) && trace_ready;
        free = DEPTH - exp_q.size() + (pop ? 1 : 0);
        if (pop) void'(exp_q.pop_front());
        hev = capture_en && hilo_write_en;
        gev = capture_en && (wb_reg_waddr != 0) && (wb_reg_wdata != 0);
        if (hev) begin
          if (free > 0) begin
            exp_q.push_back(mk(2'd1, 5'd0, hilo_wval, tb_cyc));
            free--;
          end else model_drop();
        end
        if (gev) begin
          if (free > 0) begin
            exp_q.push_back(mk(2'd0, wb_reg_waddr, {32'd0, wb_reg_wdata}, tb_cyc));
            free--;
          end else model_drop();
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk_50M);
    #1;
  endtask

  task automatic idle_inputs();
    wb_reg_waddr  = '0;
    wb_reg_wdata  = '0;
    hilo_write_en = 1'b0;
    hilo_wval     = '0;
  endtask

  task automatic gpr_write(input logic [4:0] a, input logic [31:0] d);
    wb_reg_waddr = a;
    wb_reg_wdata = d;
    step();
    idle_inputs();
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  task automatic drain();
    trace_ready = 1'b1;
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) step();
    trace_ready = 1'b0;
    n_checks++;
    if (exp_q.size() != 0 || trace_valid !== 1'b0)
      $display("FAIL drain_timeout: got %0d left valid=%0b expected 0 left valid=0",
               exp_q.size(), trace_valid);
    else n_pass++;
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    repeat (3) @(posedge clk_50M);
    #1 reset_btn = 1'b0;
    n_checks++;
    if ({trace_valid, level, overflow, drop_count} !== '0)
      $display("FAIL reset_state: got valid=%0b level=%0d ovf=%0b drops=%0d expected all 0",
               trace_valid, level, overflow, drop_count);
    else n_pass++;
    n_checks++;
    if ({trace_kind, trace_addr, trace_data, trace_cycle} !== '0)
      $display("FAIL reset_payload: got %0h expected 0",
               {trace_kind, trace_addr, trace_data, trace_cycle});
    else n_pass++;
  endtask

  task automatic test_single_gpr();
    capture_en  = 1'b1;
    trace_ready = 1'b0;
    do_clear();
    repeat (7) step();
    wb_reg_waddr = 5'd5;
    wb_reg_wdata = 32'h1234_5678;
    n_checks++;
    if (trace_valid !== 1'b0) $display("FAIL single_pre_valid: got %0b expected 0", trace_valid);
    else n_pass++;
    step();
    idle_inputs();
    n_checks++;
    if (trace_valid !== 1'b1) $display("FAIL single_valid: got %0b expected 1", trace_valid);
    else n_pass++;
    n_checks++;
    if ({trace_kind, trace_addr, trace_data} !== {2'd0, 5'd5, 64'h1234_5678})
      $display("FAIL single_payload: got k=%0d a=%0d d=%0h expected k=0 a=5 d=12345678",
               trace_kind, trace_addr, trace_data);
    else n_pass++;
    n_checks++;
    if (trace_cycle !== stamp(32'd7))
      $display("FAIL single_cycle: got %0d expected %0d", trace_cycle, stamp(32'd7));
    else n_pass++;
    drain();
  endtask

  task automatic test_zero_filter();
    gpr_write(5'd3, 32'd0);
    gpr_write(5'd0, 32'hFFFF);
    step();
    n_checks++;
    if ({trace_valid, level, drop_count} !== '0)
      $display("FAIL zero_filter: got valid=%0b level=%0d drops=%0d expected 0",
               trace_valid, level, drop_count);
    else n_pass++;
  endtask

  task automatic test_simultaneous();
    logic [CYC_WIDTH-1:0] cyc0;
    hilo_write_en = 1'b1;
    hilo_wval     = 64'h0000_0001_0000_0002;
    wb_reg_waddr  = 5'd8;
    wb_reg_wdata  = 32'hA;
    cyc0          = tb_cyc;
    step();
    idle_inputs();
    n_checks++;
    if (level !== LW'(2)) $display("FAIL simul_level: got %0d expected 2", level);
    else n_pass++;
    n_checks++;
    if ({trace_kind, trace_addr, trace_data, trace_cycle} !==
        {2'd1, 5'd0, 64'h0000_0001_0000_0002, stamp(cyc0)})
      $display("FAIL simul_first: got k=%0d a=%0d d=%0h c=%0d expected HILO entry",
               trace_kind, trace_addr, trace_data, trace_cycle);
    else n_pass++;
    trace_ready = 1'b1;
    step();
    trace_ready = 1'b0;
    n_checks++;
    if ({trace_kind, trace_addr, trace_data, trace_cycle} !== {2'd0, 5'd8, 64'hA, stamp(cyc0)})
      $display("FAIL simul_second: got k=%0d a=%0d d=%0h c=%0d expected GPR 8=A",
               trace_kind, trace_addr, trace_data, trace_cycle);
    else n_pass++;
    drain();
  endtask

  task automatic test_overflow();
    do_clear();
    for (int i = 0; i < 6; i++) gpr_write(5'(i + 1), 32'(i + 100));
    n_checks++;
    if ({level, overflow, drop_count} !== {LW'(4), 1'b1, 16'd2})
      $display("FAIL overflow_state: got level=%0d ovf=%0b drops=%0d expected 4 1 2",
               level, overflow, drop_count);
    else n_pass++;
    n_checks++;
    if (trace_data !== 64'd100) $display("FAIL overflow_head: got %0d expected 100", trace_data);
    else n_pass++;
    drain();
  endtask

  task automatic test_full_pop_dual();
    for (int i = 0; i < 4; i++) gpr_write(5'(i + 10), 32'(i + 200));
    n_checks++;
    if (level !== LW'(4)) $display("FAIL fulldual_fill: got %0d expected 4", level);
    else n_pass++;
    trace_ready   = 1'b1;
    hilo_write_en = 1'b1;
    hilo_wval     = 64'hDEAD_BEEF_CAFE_F00D;
    wb_reg_waddr  = 5'd20;
    wb_reg_wdata  = 32'h55;
    step();
    idle_inputs();
    trace_ready = 1'b0;
    n_checks++;
    if ({level, drop_count} !== {LW'(4), 16'd3})
      $display("FAIL fulldual_state: got level=%0d drops=%0d expected 4 3", level, drop_count);
    else n_pass++;
    n_checks++;
    if (trace_data !== 64'd201) $display("FAIL fulldual_head: got %0d expected 201", trace_data);
    else n_pass++;
    drain();
  endtask

  task automatic test_clear();
    gpr_write(5'd1, 32'h11);
    gpr_write(5'd2, 32'h22);
    clear        = 1'b1;
    trace_ready  = 1'b1;
    wb_reg_waddr = 5'd9;
    wb_reg_wdata = 32'd77;
    step();
    clear       = 1'b0;
    trace_ready = 1'b0;
    idle_inputs();
    n_checks++;
    if ({trace_valid, level, overflow, drop_count} !== '0)
      $display("FAIL clear_state: got valid=%0b level=%0d ovf=%0b drops=%0d expected all 0",
               trace_valid, level, overflow, drop_count);
    else n_pass++;
    step();
    n_checks++;
    if (level !== '0) $display("FAIL clear_no_store: got %0d expected 0", level);
    else n_pass++;
  endtask

  task automatic test_reset_mid_drain();
    gpr_write(5'd4, 32'h44);
    gpr_write(5'd5, 32'h55);
    gpr_write(5'd6, 32'h66);
    trace_ready = 1'b1;
    step();
    #3 reset_btn = 1'b1;
    #1;
    n_checks++;
    if ({trace_valid, level, trace_data} !== '0)
      $display("FAIL reset_async: got valid=%0b level=%0d data=%0h expected 0",
               trace_valid, level, trace_data);
    else n_pass++;
    #7 reset_btn = 1'b0;
    trace_ready = 1'b0;
    step();
    n_checks++;
    if ({trace_valid, level, drop_count} !== '0)
      $display("FAIL reset_after: got valid=%0b level=%0d drops=%0d expected 0",
               trace_valid, level, drop_count);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 80; i++) begin
      capture_en    = ($urandom_range(0, 9) != 0);
      hilo_write_en = $urandom_range(0, 1);
      hilo_wval     = {$urandom, $urandom};
      wb_reg_waddr  = 5'($urandom_range(0, 31));
      wb_reg_wdata  = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      trace_ready   = $urandom_range(0, 1);
      step();
    end
    idle_inputs();
    capture_en = 1'b1;
    drain();
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    test_reset();
    test_single_gpr();
    test_zero_filter();
    test_simultaneous();
    test_overflow();
    test_full_pop_dual();
    test_clear();
    test_reset_mid_drain();
    test_back_to_back();
    step();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
